// File: rtl/vga_axil_regs.sv
// AXI-Lite register slave for the VGA controller: CTRL/BG/FG rw registers
// plus a read-only live STATUS word, with independent write and read FSMs.
module vga_axil_regs #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   ctrl_o,
  output logic [DATA_W-1:0]   bg_color_o,
  output logic [DATA_W-1:0]   fg_color_o,
  input  logic [DATA_W-1:0]   status_i
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [2:0][DATA_W-1:0] cfg;
  logic                   aw_held, w_held;
  logic [ADDR_W-1:0]      aw_addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [STRB_W-1:0]      wstrb_q;

  logic                   aw_fire, w_fire, commit, wr_err;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data, wr_cur, wr_merged;
  logic [STRB_W-1:0]      wr_strb;

  logic                   ar_fire, rd_oor;
  logic [DATA_W-1:0]      rd_val;
  logic                   unused_addr_lsb;

  assign ctrl_o     = cfg[0];
  assign bg_color_o = cfg[1];
  assign fg_color_o = cfg[2];

  // Byte offset within a word carries no meaning in this map.
  assign unused_addr_lsb = ^{wr_addr[1:0], araddr[1:0]};

  // A channel already captured uses its held copy; otherwise the live bus.
  always_comb begin
    aw_fire   = awready && awvalid;
    w_fire    = wready && wvalid;
    wr_addr   = aw_held ? aw_addr_q : awaddr;
    wr_data   = w_held ? wdata_q : wdata;
    wr_strb   = w_held ? wstrb_q : wstrb;
    wr_err    = (|wr_addr[ADDR_W-1:4]) || (wr_addr[3:2] == 2'd3);
    commit    = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    wr_cur    = '0;
    wr_merged = '0;
    case (wr_addr[3:2])
      2'd0:    wr_cur = cfg[0];
      2'd1:    wr_cur = cfg[1];
      2'd2:    wr_cur = cfg[2];
      default: wr_cur = '0;
    endcase
    for (int b = 0; b < STRB_W; b++)
      wr_merged[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : wr_cur[8*b +: 8];
  end

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_n = W_RESP;
      W_RESP:  if (bvalid && bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      cfg       <= '0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      if (commit) begin
        if (!wr_err) begin
          case (wr_addr[3:2])
            2'd0:    cfg[0] <= wr_merged;
            2'd1:    cfg[1] <= wr_merged;
            2'd2:    cfg[2] <= wr_merged;
            default: ;
          endcase
        end
        bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        bvalid  <= 1'b1;
        awready <= 1'b0;
        wready  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else if (w_state == W_IDLE) begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
          awready   <= 1'b0;
        end
        if (w_fire) begin
          w_held  <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
          wready  <= 1'b0;
        end
      end else if (bvalid && bready) begin
        bvalid  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end
    end
  end

  // Reads see registers before any commit on the same edge.
  always_comb begin
    ar_fire = arready && arvalid;
    rd_oor  = |araddr[ADDR_W-1:4];
    rd_val  = '0;
    if (!rd_oor) begin
      case (araddr[3:2])
        2'd0:    rd_val = cfg[0];
        2'd1:    rd_val = cfg[1];
        2'd2:    rd_val = cfg[2];
        default: rd_val = status_i;
      endcase
    end
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_n = R_DATA;
      R_DATA:  if (rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_n;
      if (ar_fire) begin
        rdata   <= rd_val;
        rresp   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        rvalid  <= 1'b1;
        arready <= 1'b0;
      end else if (rvalid && rready) begin
        rvalid  <= 1'b0;
        arready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_axil_regs.sv
// Bench for vga_axil_regs: vector table, hand-written corner sequences and a
// randomized run against an array-based register model.
module tb_vga_axil_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] ctrl_o, bg_color_o, fg_color_o, status_i;

  vga_axil_regs #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ctrl_o(ctrl_o), .bg_color_o(bg_color_o), .fg_color_o(fg_color_o),
    .status_i(status_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m [3];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: strobe-merge into an array, SLVERR for STATUS or out of range.
  function automatic logic [1:0] model_wr(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] mask;
    if (a >= 32'h10 || a[3:2] == 2'd3) return 2'b10;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    m[a[3:2]] = (m[a[3:2]] & ~mask) | (d & mask);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a >= 32'h10) return 32'h0;
    if (a[3:2] == 2'd3) return status_i;
    return m[a[3:2]];
  endfunction

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int da, input int dw, output logic [1:0] resp);
    bit ad, wd, acc_a, acc_w, got;
    int cyc;
    ad = 0; wd = 0; got = 0; cyc = 0; resp = 2'b11;
    @(negedge clk);
    while (!(ad && wd) && cyc < 40) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !ad && cyc >= da;
      wvalid  = !wd && cyc >= dw;
      acc_a = awvalid && awready;
      acc_w = wvalid && wready;
      @(negedge clk);
      ad = ad | acc_a; wd = wd | acc_w; cyc++;
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("wr_timeout", 32'd0, 32'd1);
    else begin
      resp = bresp;
      @(negedge clk);
    end
    bready = 0;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                        output int lat);
    bit acc, got;
    got = 0; lat = -1; d = 32'hX; resp = 2'b11;
    @(negedge clk);
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      acc = arready;
      @(negedge clk);
      if (acc) break;
    end
    arvalid = 0;
    rready = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) begin got = 1; lat = i; end
      else @(negedge clk);
    end
    if (!got) chk("rd_timeout", 32'd0, 32'd1);
    else begin
      d = rdata; resp = rresp;
      @(negedge clk);
    end
    rready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) m[i] = 32'h0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, a, wd_v, hold_rdata;
    int          lat;

    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; status_i = 32'h5A5A_0001;
    for (int i = 0; i < 3; i++) m[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst = 0;

    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready",  {31'd0, wready},  32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_resp",    {28'd0, bresp, rresp}, 32'd0);

    vt[0]  = '{0, 32'h0,  32'h0,         4'h0, 2'b00, 32'h0};
    vt[1]  = '{0, 32'h4,  32'h0,         4'h0, 2'b00, 32'h0};
    vt[2]  = '{0, 32'h8,  32'h0,         4'h0, 2'b00, 32'h0};
    vt[3]  = '{0, 32'hC,  32'h0,         4'h0, 2'b00, 32'h5A5A_0001};
    vt[4]  = '{1, 32'h3,  32'h4,         4'hF, 2'b00, 32'h0};
    vt[5]  = '{0, 32'h3,  32'h0,         4'h0, 2'b00, 32'h4};
    vt[6]  = '{1, 32'h4,  32'hAABB_CCDD, 4'hF, 2'b00, 32'h0};
    vt[7]  = '{1, 32'hC,  32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vt[8]  = '{1, 32'h10, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vt[9]  = '{0, 32'h10, 32'h0,         4'h0, 2'b10, 32'h0};
    vt[10] = '{0, 32'h4,  32'h0,         4'h0, 2'b00, 32'hAABB_CCDD};
    vt[11] = '{1, 32'h8,  32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vt[12] = '{0, 32'h8,  32'h0,         4'h0, 2'b00, 32'h0};
    vt[13] = '{0, 32'h0,  32'h0,         4'h0, 2'b00, 32'h4};

    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) begin
        axi_wr(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, resp);
        chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vt[i].exp_resp});
        void'(model_wr(vt[i].addr, vt[i].data, vt[i].strb));
      end else begin
        axi_rd(vt[i].addr, d, resp, lat);
        chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vt[i].exp_resp});
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        chk($sformatf("vec%0d_rlat", i), lat, 0);
      end
    end
    chk("tbl_ctrl", ctrl_o, 32'h4);
    chk("tbl_bg", bg_color_o, 32'hAABB_CCDD);
    chk("tbl_fg", fg_color_o, 32'h0);

    // W three cycles ahead of AW, partial strobes
    @(negedge clk);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("ord_wready_drop", {31'd0, wready}, 32'd0);
    repeat (2) begin
      chk("ord_no_bvalid", {31'd0, bvalid}, 32'd0);
      chk("ord_awready", {31'd0, awready}, 32'd1);
      @(negedge clk);
    end
    awaddr = 32'h4; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("ord_bvalid", {31'd0, bvalid}, 32'd1);
    chk("ord_bresp", {30'd0, bresp}, 32'd0);
    chk("ord_bg", bg_color_o, 32'hAA22_CC44);
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("ord_bvalid_clr", {31'd0, bvalid}, 32'd0);
    m[1] = 32'hAA22_CC44;

    // Concurrent write and read of FG under backpressure; read sees old value
    hold_rdata = m[2];
    @(negedge clk);
    awaddr = 32'h8; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h8; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    m[2] = 32'h1234_5678;
    repeat (5) begin
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("bp_rdata", rdata, hold_rdata);
      chk("bp_resp", {28'd0, bresp, rresp}, 32'd0);
      chk("bp_readies", {29'd0, awready, wready, arready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_fg", fg_color_o, 32'h1234_5678);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    chk("bp_done_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("bp_done_readies", {29'd0, awready, wready, arready}, 32'd7);

    // Reset while a response is pending
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("rstmid_bvalid_pre", {31'd0, bvalid}, 32'd1);
    do_reset();
    chk("rstmid_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rstmid_bg", bg_color_o, 32'h0);
    chk("rstmid_awready", {31'd0, awready}, 32'd1);

    // Reset after an AW-only capture drops the address
    awaddr = 32'h0; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("awonly_awready", {31'd0, awready}, 32'd0);
    do_reset();
    wdata = 32'hFF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (4) begin
      chk("wonly_no_bvalid", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
    end
    chk("wonly_ctrl", ctrl_o, 32'h0);
    awaddr = 32'h4; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("wonly_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wonly_bresp", {30'd0, bresp}, 32'd0);
    chk("wonly_bg", bg_color_o, 32'hFF);
    chk("wonly_ctrl2", ctrl_o, 32'h0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    m[1] = 32'hFF;

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      status_i = $urandom;
      case ($urandom_range(0, 4))
        0, 1, 2: a = {26'd0, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
        3:       a = {28'd0, 2'd3, 2'($urandom_range(0, 3))};
        default: begin
          a = $urandom;
          if (a < 32'h10) a = a | 32'h100;
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        wd_v = $urandom;
        d = {28'd0, 4'($urandom_range(0, 15))};
        axi_wr(a, wd_v, d[3:0], $urandom_range(0, 3), $urandom_range(0, 3), resp);
        chk("rnd_bresp", {30'd0, resp}, {30'd0, model_wr(a, wd_v, d[3:0])});
        chk("rnd_regs", ctrl_o ^ {bg_color_o[15:0], bg_color_o[31:16]} ^ ~fg_color_o,
            m[0] ^ {m[1][15:0], m[1][31:16]} ^ ~m[2]);
      end else begin
        axi_rd(a, d, resp, lat);
        chk("rnd_rdata", d, model_rd(a));
        chk("rnd_rresp", {30'd0, resp}, (a >= 32'h10) ? 32'd2 : 32'd0);
      end
    end
    chk("end_ctrl", ctrl_o, m[0]);
    chk("end_bg", bg_color_o, m[1]);
    chk("end_fg", fg_color_o, m[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_axil_regs.md
# vga_axil_regs

AXI-Lite responder that terminates the control bus of the VGA controller and holds its configuration registers. It accepts single-beat writes and reads from the bus initiator and returns OKAY/SLVERR responses. It drives the register values to the timing and pixel logic and reports a status word back on the bus. Write and read channels are handled by two independent state machines.

## Interface
- ADDR_W, 32, width of awaddr/araddr
- DATA_W, 32, width of wdata/rdata and of every register
- clk  in  1  bus and register clock
- rst  in  1  synchronous, active-high reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  / awready  out  1  write-address handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- wvalid  in  1  / wready  out  1  write-data handshake
- bresp  out  2  write response (OKAY=2'b00, SLVERR=2'b10)
- bvalid  out  1  / bready  in  1  write-response handshake
- araddr  in  ADDR_W  read address
- arvalid  in  1  / arready  out  1  read-address handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  / rready  in  1  read-data handshake
- ctrl_o  out  DATA_W  CTRL register (bit0 enable)
- bg_color_o  out  DATA_W  BG_COLOR register
- fg_color_o  out  DATA_W  FG_COLOR register
- status_i  in  DATA_W  live status word, read-only

## Operation
- Register map, word index = addr[3:2], addr[1:0] ignored:
  - 0 CTRL, rw
  - 1 BG_COLOR, rw
  - 2 FG_COLOR, rw
  - 3 STATUS, ro
- Address is out of range when addr[ADDR_W-1:4] != 0.
- Write FSM states W_IDLE, W_RESP:
  - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - Once both are held, commit the write and go to W_RESP.
  - Commit: the selected rw register updates bytes where wstrb=1; no other register changes.
  - bresp: OKAY for rw targets; SLVERR for STATUS or an out-of-range address, with no register change.
  - W_RESP: bvalid=1, awready=0, wready=0. On bvalid&&bready, clear the captured flags and return to W_IDLE.
- Read FSM states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid, latch rdata/rresp and go to R_DATA.
  - Out-of-range read: rdata=0, rresp=SLVERR.
  - R_DATA: rvalid=1, arready=0; rdata/rresp held stable. On rready, return to R_IDLE.
- The read and write FSMs run concurrently.
  - A read accepted in the same cycle a write commits to the same register returns the pre-write value.
  - STATUS reads sample status_i at the AR handshake edge.

## Timing
- Reset (rst=1 at a clk edge):
  - All registers = 0.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - Both FSMs go to IDLE and drop captured AW/W.
- Reset mid-transaction discards the transaction without a response. A register write takes effect only if its commit edge precedes reset.
- Write latency:
  - AW and W accepted at edge N: register visible on outputs after edge N, bvalid=1 from cycle N+1.
  - AW at edge N, W at edge M>N: awready=0 from N+1; commit at M; bvalid from M+1.
- Read latency: AR accepted at edge N -> rvalid=1 from cycle N+1.
- Throughput: with bready/rready held high, back-to-back transactions take 2 cycles each per channel.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset value:
  - Stimulus: hold rst 2 cycles, then read all 4 addresses.
  - Required: rdata=0 for indices 0-2 and =status_i for index 3, rresp=OKAY, rvalid one cycle after arvalid.
- Write/read round trip:
  - Stimulus: write 0x0000_0004 to addr 0x3, read addr 0x3.
  - Required: bresp=OKAY, rdata=0x0000_0004, ctrl_o=0x4.
- Strobes and channel order:
  - Stimulus: BG_COLOR=0xAABBCCDD; send W (wdata 0x11223344, wstrb 4'b0101) 3 cycles before AW addr 0x4.
  - Required: wready drops after W, bvalid 1 cycle after AW, bg_color_o=0xAA22CC44.
- Error responses:
  - Stimulus 1: write to addr 0xC. Required: SLVERR, registers unchanged.
  - Stimulus 2: write and read at addr 0x10. Required: SLVERR both, rdata=0.
- Backpressure:
  - Stimulus: hold bready=0 and rready=0 for 5 cycles.
  - Required: bvalid, rvalid, rdata, rresp stable; awready/wready/arready=0 until each handshake completes.
- Reset mid-operation:
  - Stimulus: assert rst while bvalid=1 and after an AW-only capture.
  - Required: bvalid=0 next cycle, captured AW dropped. A subsequent W alone produces no response until a new AW arrives.
